// File: rtl/esco_window_ctrl.sv
// eSCO reserved-slot / retransmission-window sequencer for a single eSCO link.
// Tracks the interval phase in slots, opens the window at Desco, and owns txscoSEQN.
module esco_window_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk_6M,
    input  logic             rst,
    input  logic             ms_tslot_p,
    input  logic             regi_esco_en,
    input  logic [CNT_W-1:0] regi_Tesco,
    input  logic [CNT_W-1:0] regi_Desco,
    input  logic [CNT_W-1:0] regi_Wesco,
    input  logic             esco_ack_p,
    output logic             eSCOwindow,
    output logic             eSCOwindow_endp,
    output logic             reserved_slot,
    output logic             esco_retx_slot,
    output logic             esco_acked,
    output logic             txscoSEQN,
    output logic             cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_WAIT,
        S_RSV,
        S_RETX
    } state_t;

    localparam logic [CNT_W:0] ONE_X = (CNT_W+1)'(1);
    localparam logic [CNT_W:0] TWO_X = (CNT_W+1)'(2);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic             en_q;
    logic             window_q, window_d;
    logic             endp_q, endp_d;
    logic             reserved_q, reserved_d;
    logic             retx_q, retx_d;
    logic             acked_q, acked_d;
    logic             seqn_q, seqn_d;
    logic             cfg_err_q, cfg_err_d;

    logic             cfg_bad;
    logic [CNT_W:0]   pcnt_p1;
    logic [CNT_W:0]   wcnt_p1;
    logic [CNT_W-1:0] pcnt_inc;
    logic             close_evt;
    logic             rsv_entry;

    always_comb begin
        cfg_bad = (regi_Tesco == '0) || (regi_Desco >= regi_Tesco) ||
                  (({1'b0, regi_Wesco} + TWO_X) > {1'b0, regi_Tesco});
        cfg_err_d = cfg_bad;

        // Phase counter wraps at Tesco; >= keeps it bounded if Tesco shrinks on the fly.
        pcnt_p1  = {1'b0, pcnt_q} + ONE_X;
        pcnt_inc = (pcnt_p1 >= {1'b0, regi_Tesco}) ? '0 : pcnt_p1[CNT_W-1:0];
        wcnt_p1  = {1'b0, wcnt_q} + ONE_X;

        state_d   = state_q;
        pcnt_d    = pcnt_q;
        wcnt_d    = wcnt_q;
        acked_d   = acked_q;
        seqn_d    = seqn_q;
        close_evt = 1'b0;
        rsv_entry = 1'b0;

        if (window_q && esco_ack_p) begin
            acked_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                pcnt_d = '0;
                wcnt_d = '0;
                if (regi_esco_en && !en_q && !cfg_bad) begin
                    state_d = S_SYNC;
                    seqn_d  = 1'b1;
                    acked_d = 1'b0;
                end
            end
            S_SYNC: begin
                if (ms_tslot_p) begin
                    pcnt_d = '0;
                    if (regi_Desco == '0) begin
                        rsv_entry = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (ms_tslot_p) begin
                    pcnt_d = pcnt_inc;
                    if (pcnt_inc == regi_Desco) begin
                        rsv_entry = 1'b1;
                    end
                end
            end
            S_RSV: begin
                if (ms_tslot_p) begin
                    pcnt_d = pcnt_inc;
                    if (wcnt_q == '0) begin
                        wcnt_d = 1'b1;
                    end else begin
                        wcnt_d = '0;
                        if (regi_Wesco == '0) begin
                            close_evt = 1'b1;
                        end else begin
                            state_d = S_RETX;
                        end
                    end
                end
            end
            S_RETX: begin
                if (ms_tslot_p) begin
                    pcnt_d = pcnt_inc;
                    if (wcnt_p1 >= {1'b0, regi_Wesco}) begin
                        close_evt = 1'b1;
                    end else begin
                        wcnt_d = wcnt_p1[CNT_W-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A window filling the whole interval closes on the same edge the next one opens.
        if (close_evt) begin
            state_d = S_WAIT;
            wcnt_d  = '0;
            seqn_d  = ~seqn_q;
            if (pcnt_inc == regi_Desco) begin
                rsv_entry = 1'b1;
            end
        end

        if (rsv_entry) begin
            state_d = S_RSV;
            wcnt_d  = '0;
            acked_d = 1'b0;
        end

        endp_d = close_evt;

        // Abort: link disabled or config went illegal; sequence number is left alone.
        if ((state_q != S_IDLE) && (!regi_esco_en || cfg_bad)) begin
            state_d = S_IDLE;
            pcnt_d  = '0;
            wcnt_d  = '0;
            seqn_d  = seqn_q;
            endp_d  = window_q;
        end

        window_d   = (state_d == S_RSV) || (state_d == S_RETX);
        reserved_d = (state_d == S_RSV);
        retx_d     = (state_d == S_RETX) && !acked_d;
    end

    // Edge detector follows the pin even in reset so a held enable does not re-arm.
    always_ff @(posedge clk_6M) begin
        en_q <= regi_esco_en;
    end

    always_ff @(posedge clk_6M) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pcnt_q     <= '0;
            wcnt_q     <= '0;
            window_q   <= 1'b0;
            endp_q     <= 1'b0;
            reserved_q <= 1'b0;
            retx_q     <= 1'b0;
            acked_q    <= 1'b0;
            seqn_q     <= 1'b1;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            wcnt_q     <= wcnt_d;
            window_q   <= window_d;
            endp_q     <= endp_d;
            reserved_q <= reserved_d;
            retx_q     <= retx_d;
            acked_q    <= acked_d;
            seqn_q     <= seqn_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign eSCOwindow      = window_q;
    assign eSCOwindow_endp = endp_q;
    assign reserved_slot   = reserved_q;
    assign esco_retx_slot  = retx_q;
    assign esco_acked      = acked_q;
    assign txscoSEQN       = seqn_q;
    assign cfg_err         = cfg_err_q;

endmodule

// File: doc/esco_window_ctrl.md
Name: esco_window_ctrl

Overview:
- Generates the eSCO reserved-slot and retransmission-window timing for one eSCO link.
- Replaces the constant eSCOwindow / eSCOwindow_endp / reserved_slot tie-offs feeding ARQ/flow control, and owns txscoSEQN.
- Driven by the master/slave slot pulse and MCU configuration registers; consumes the eSCO-accept indication coming back from RX ARQ.

Parameters:
- CNT_W, 8, width of Tesco/Desco/Wesco fields and of the internal slot counters.

Ports:
- clk_6M  in  1  6 MHz system clock
- rst  in  1  synchronous active-high reset
- ms_tslot_p  in  1  one-cycle slot-boundary pulse (every 625 us)
- regi_esco_en  in  1  link enable; a rising edge arms the link
- regi_Tesco  in  CNT_W  eSCO interval in slots
- regi_Desco  in  CNT_W  slot offset of the reserved instant inside the interval
- regi_Wesco  in  CNT_W  retransmission window length in slots
- esco_ack_p  in  1  one-cycle pulse: eSCO payload accepted/ACKed
- eSCOwindow  out  1  reserved slots plus retransmission window active
- eSCOwindow_endp  out  1  one-cycle pulse when the window closes
- reserved_slot  out  1  high during the 2 reserved slots
- esco_retx_slot  out  1  high in retransmission slots while not yet ACKed
- esco_acked  out  1  ACK received in current/last window
- txscoSEQN  out  1  eSCO sequence number
- cfg_err  out  1  illegal configuration flag

Behaviour:
- Reset values:
  - All outputs 0 except txscoSEQN = 1.
  - State IDLE; pcnt = 0, wcnt = 0.
- Register timing:
  - All outputs are registered.
  - Slot-driven changes occur on the clk_6M edge that samples ms_tslot_p = 1 and are visible the following cycle.
- Config check (combinational, registered into cfg_err):
  - Error if Tesco == 0, Desco >= Tesco, or Wesco + 2 > Tesco.
  - While cfg_err = 1 the FSM is held in IDLE.
- States:
  - IDLE: regi_esco_en rising edge with no cfg_err -> SYNC. On the same edge txscoSEQN <= 1 and esco_acked <= 0.
  - SYNC: next ms_tslot_p loads pcnt = 0. If Desco == 0 -> RSV, else -> WAIT.
  - WAIT: each ms_tslot_p increments pcnt modulo Tesco. When the incremented value equals Desco -> RSV.
  - RSV: entry sets eSCOwindow = 1, reserved_slot = 1, esco_acked = 0, wcnt = 0.
    - Runs 2 slot pulses, pcnt still advancing.
    - After the 2nd pulse: Wesco == 0 -> CLOSE, else -> RETX.
  - RETX: reserved_slot = 0; esco_retx_slot = !esco_acked.
    - wcnt counts slot pulses.
    - After Wesco pulses -> CLOSE.
  - CLOSE (single cycle, on the closing slot edge):
    - eSCOwindow <= 0, eSCOwindow_endp <= 1 for exactly one cycle, txscoSEQN toggles.
    - Continue in WAIT (pcnt keeps counting).
- pcnt:
  - Free-runs modulo Tesco in every non-IDLE state, so instants repeat exactly every Tesco slots.
  - The window may straddle the pcnt wrap from Tesco-1 to 0.
- esco_ack_p:
  - Sampled only while eSCOwindow = 1; ignored otherwise.
  - Sets esco_acked the next cycle.
  - esco_acked holds until the next RSV entry, so it stays visible after the window closes.
- Simultaneous events:
  - esco_ack_p in the same cycle as the closing ms_tslot_p: the ack is still recorded (esco_acked = 1) and the window closes normally.
  - regi_esco_en falling edge at any point: next cycle FSM -> IDLE and all window outputs -> 0.
    - If eSCOwindow was 1, eSCOwindow_endp pulses once.
    - txscoSEQN does NOT toggle on abort.
  - Register changes while active are used at the next comparison; no resync. Illegal values force cfg_err = 1 and IDLE, following the abort rules above.
- rst overrides everything, including mid-window; no endp pulse is generated by reset.

Test Plan:
1. Tesco=6, Desco=2, Wesco=2, enable, pulse slots continuously -> eSCOwindow high for slot pulses 3-6 of every 6.
   - reserved_slot for the first 2 of those 4, esco_retx_slot for the last 2.
   - endp pulses every 6 slots; txscoSEQN 1,0,1,...
2. Same config, esco_ack_p in the 2nd reserved slot -> esco_acked = 1; esco_retx_slot stays 0 for the whole RETX phase; esco_acked clears at the next RSV.
3. Tesco=4, Desco=3, Wesco=2 -> window wraps pcnt 3,0,1,2; spacing between instants stays exactly 4 slots.
4. Tesco=4, Wesco=3 -> cfg_err = 1 and no window output. Rewrite Wesco=2 and toggle enable -> normal operation, cfg_err = 0.
5. Drop regi_esco_en in the RETX phase -> one endp pulse, window 0 the next cycle, txscoSEQN unchanged. Re-enable -> txscoSEQN = 1.
6. Assert rst mid-RSV -> all outputs 0, txscoSEQN = 1, no endp pulse; outputs remain idle until the next enable rising edge.
